// File: rtl/product_q15_out_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : product_q15_out_stage_if
//  Description : Handshake bundle for the Q15 product output stage.
//                Upstream side : prod_in / prod_valid / prod_ready
//                Downstream    : q_out / q_valid / q_ready / q_sat
//                slave  modport : the output stage itself
//                master modport : whatever drives products and consumes Q15
//  Revision    : 1.0  initial release
// ============================================================================
interface product_q15_out_stage_if #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 16
);
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [OUT_W-1:0]  q_out;
    logic              q_valid;
    logic              q_ready;
    logic              q_sat;

    modport master (
        output prod_in, prod_valid, q_ready,
        input  prod_ready, q_out, q_valid, q_sat
    );

    modport slave (
        input  prod_in, prod_valid, q_ready,
        output prod_ready, q_out, q_valid, q_sat
    );
endinterface
`default_nettype wire

// File: rtl/product_q15_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : product_q15_out_stage
//  Description : Output stage behind the final carry-propagate adder of the
//                16x16 signed multiplier. Converts the Q30 product to Q15
//                with optional round-half-up and saturation to OUT_W bits,
//                then presents it through a 2-entry skid buffer. Counts
//                accepted samples that saturated (sticky at all-ones).
//  Ports       : sys_clk    - clock, rising edge
//                sys_rst_n  - asynchronous active-low reset
//                bus        - handshake bundle (slave modport):
//                             prod_in/prod_valid/prod_ready  (input side)
//                             q_out/q_valid/q_ready/q_sat    (output side)
//                clr_cnt    - synchronous clear of sat_cnt
//                sat_cnt    - saturation event counter
//  Options     : `define Q15_ROUND_EN for round-half-up; undefined gives
//                truncation (arithmetic shift toward minus infinity).
//  Revision    : 1.0  initial release
// ============================================================================
module product_q15_out_stage #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 16,
    parameter int FRAC   = 15,
    parameter int CNT_W  = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    product_q15_out_stage_if.slave      bus,
    input  logic                        clr_cnt,
    output logic [CNT_W-1:0]            sat_cnt
);

    // One guard bit so the rounding addend can never overflow the product.
    localparam int EXT_W = PROD_W + 1;

`ifdef Q15_ROUND_EN
    localparam logic signed [EXT_W-1:0] c_round_add = EXT_W'(1) << (FRAC - 1);
`else
    localparam logic signed [EXT_W-1:0] c_round_add = '0;
`endif
    localparam logic signed [EXT_W-1:0] c_max = EXT_W'((2 ** (OUT_W - 1)) - 1);
    // Bitwise complement of +max is exactly -2^(OUT_W-1).
    localparam logic signed [EXT_W-1:0] c_min = ~c_max;

    // ------------------------------------------------------------------
    // Conversion: combinational on prod_in
    // ------------------------------------------------------------------
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_rnd;
    logic signed [EXT_W-1:0] w_shr;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic                    w_sat;
    logic [OUT_W-1:0]        w_res;

    assign w_ext    = {bus.prod_in[PROD_W-1], bus.prod_in};
    assign w_rnd    = w_ext + c_round_add;
    assign w_shr    = w_rnd >>> FRAC;
    assign w_sat_hi = (w_shr > c_max);
    assign w_sat_lo = (w_shr < c_min);
    assign w_sat    = w_sat_hi | w_sat_lo;
    assign w_res    = w_sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                      w_sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 w_shr[OUT_W-1:0];

    // ------------------------------------------------------------------
    // Skid buffer state
    // ------------------------------------------------------------------
    logic               main_valid_q, main_valid_d;
    logic [OUT_W-1:0]   main_data_q,  main_data_d;
    logic               main_sat_q,   main_sat_d;
    logic               skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0]   skid_data_q,  skid_data_d;
    logic               skid_sat_q,   skid_sat_d;
    logic               prod_ready_q, prod_ready_d;
    logic [CNT_W-1:0]   sat_cnt_q,    sat_cnt_d;

    logic               w_in_xfer;
    logic               w_out_xfer;

    assign w_in_xfer  = bus.prod_valid & prod_ready_q;
    assign w_out_xfer = main_valid_q & bus.q_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_sat_d   = main_sat_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sat_d   = skid_sat_q;

        // Drain first: main either refills from skid or empties.
        if (w_out_xfer) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_sat_d   = skid_sat_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        // An input transfer implies the skid is empty (prod_ready_q), so
        // the drain above never competes with a skid write.
        if (w_in_xfer) begin
            if (!main_valid_q || w_out_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = w_res;
                main_sat_d   = w_sat;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = w_res;
                skid_sat_d   = w_sat;
            end
        end

        // Registered ready: never a combinational path from q_ready.
        prod_ready_d = ~skid_valid_d;
    end

    // ------------------------------------------------------------------
    // Saturation counter: clear beats increment, holds at all-ones
    // ------------------------------------------------------------------
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clr_cnt) begin
            sat_cnt_d = '0;
        end else if (w_in_xfer && w_sat && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_sat_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sat_q   <= 1'b0;
            prod_ready_q <= 1'b1;
            sat_cnt_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_sat_q   <= main_sat_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sat_q   <= skid_sat_d;
            prod_ready_q <= prod_ready_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign bus.q_valid    = main_valid_q;
    assign bus.q_out      = main_data_q;
    assign bus.q_sat      = main_sat_q;
    assign bus.prod_ready = prod_ready_q;
    assign sat_cnt        = sat_cnt_q;

endmodule
`default_nettype wire

// File: doc/product_q15_out_stage.md
Name: product_q15_out_stage

Overview:
Output stage directly downstream of the 32-bit final carry-propagate adder of the Booth-4/Wallace 16x16 signed multiplier. It accepts the 32-bit two's-complement product over a valid/ready handshake. It converts the product from Q30 to Q15, with rounding and saturation to 16 bits, and presents the result through a 2-entry skid buffer. A sticky saturation counter is kept for monitoring.

Parameters:
- PROD_W, 32, product width; bit PROD_W-1 is the sign bit.
- OUT_W, 16, output sample width, signed.
- FRAC, 15, right-shift amount (Q30 to Q15).
- CNT_W, 8, width of the saturation event counter.

Ports:
- sys_clk  input  1  single clock; all state updates on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- prod_in  input  PROD_W  signed product from the final adder.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  stage can accept; registered, equals "skid entry empty".
- q_out  output  OUT_W  Q15 result, signed.
- q_valid  output  1  q_out and q_sat are valid.
- q_ready  input  1  downstream accepts q_out this cycle.
- q_sat  output  1  sideband: the presented sample was saturated.
- sat_cnt  output  CNT_W  number of accepted samples that saturated; holds at all-ones.
- clr_cnt  input  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (sys_rst_n low, asynchronous): q_valid=0, q_out=0, q_sat=0, prod_ready=1 (skid empty), sat_cnt=0, both buffer entries invalid. Takes effect mid-transfer too; buffered data is discarded.
- Transfers: input transfer when prod_valid && prod_ready. Output transfer when q_valid && q_ready. Data on prod_in is sampled only on an input transfer.
- Conversion (combinational on prod_in, before buffering):
  - r = sext(prod_in, PROD_W+1) + 2^(FRAC-1).
  - s = r >>> FRAC (arithmetic shift).
  - If s > 2^(OUT_W-1)-1: result 0x7FFF, sat=1.
  - If s < -2^(OUT_W-1): result 0x8000, sat=1.
  - Otherwise: result s[OUT_W-1:0], sat=0.
- Buffer: main entry drives q_out/q_valid/q_sat; a skid entry sits behind it.
  - Input transfer while the main entry is empty or being drained this cycle: the result goes to main.
  - Input transfer while main is valid and q_ready=0: the result goes to skid, and prod_ready falls next cycle.
  - Output transfer while skid is valid: skid moves to main and prod_ready rises next cycle.
  - Simultaneous input and output transfer with skid empty: main reloads with the new result; throughput is 1 sample/cycle.
- Latency: a sample accepted at edge N is visible on q_out after edge N (q_valid high in cycle N+1) when the buffer is empty.
- Ordering: strict FIFO. No sample is dropped or duplicated. Output fields are held stable while q_valid && !q_ready.
- prod_ready never depends combinationally on q_ready (registered only).
- sat_cnt:
  - Increments by 1 on each input transfer whose sat=1; stops at 2^CNT_W-1.
  - clr_cnt=1 forces 0 next edge; clear wins over a simultaneous increment.

Optional Feature:
- Macro Q15_ROUND_EN.
- Defined: round-half-up as above (add 2^(FRAC-1) before the shift).
- Undefined: plain truncation; the addend is 0, giving an arithmetic shift toward minus infinity. Saturation, buffer and counter behaviour are unchanged.

Test Plan:
- Reset: hold sys_rst_n low 3 cycles, release -> q_valid=0, q_out=0x0000, prod_ready=1, sat_cnt=0.
- Saturation: prod_in=0x40000000 (-32768 x -32768), q_ready=1 -> q_out=0x7FFF, q_sat=1, sat_cnt=1. Then prod_in=0x3FFF8000 -> q_out=0x7FFF, q_sat=0, sat_cnt stays 1.
- Rounding, prod_in=0x00004000:
  - Q15_ROUND_EN defined -> q_out=0x0001.
  - Undefined -> q_out=0x0000.
- Rounding, prod_in=0xFFFFC000:
  - Defined -> q_out=0x0000.
  - Undefined -> q_out=0xFFFF.
- Backpressure: q_ready=0, offer A=0x00010000, B=0x00020000, C=0x00030000 back-to-back.
  - A and B are accepted; prod_ready drops after B; C is held.
  - Set q_ready=1 -> outputs 0x0002, 0x0004, 0x0006 in order, no duplicate or loss.
- Streaming: prod_valid=1 and q_ready=1 for 10 cycles with incrementing products -> 10 outputs on 10 consecutive cycles, latency 1. Then clr_cnt pulse coinciding with a saturating sample -> sat_cnt=0.
- Reset mid-operation: both entries full, q_ready=0, pull sys_rst_n low between edges -> q_valid=0 and prod_ready=1 immediately. After release, no stale sample appears.
